// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// Purpose:
//   Single-issue integer execute unit with a valid/ready handshake on both
//   sides. Most operations finish in one cycle and the result is registered.
//   An optional iterative shift-add multiplier retires one bit of the
//   multiplier per cycle.
//
// Build option:
//   ALU_EXEC_MUL_EN - when defined, R-type funct 011000 runs the iterative
//                     multiply. When undefined, that funct is a NOP and every
//                     operation has a latency of one cycle.
//
// Ports:
//   clk        in   clock; all state updates on its rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   operation request
//   in_ready   out  unit accepts an operation this cycle
//   alu_op     in   decoder class: 00 add, 01 sub, 10 R-type (funct), 11 or
//   funct      in   R-type function field
//   shamt      in   shift amount (shifts act on b)
//   a, b       in   operands
//   out_valid  out  result registers hold an unconsumed result
//   out_ready  in   consumer takes the result this cycle
//   result     out  registered result
//   zero       out  registered (result == 0)
//   ovf        out  registered signed overflow (ADD/SUB only)
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DONE = 2'd2;
`ifdef ALU_EXEC_MUL_EN
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(WIDTH - 1);
`endif

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
`ifdef ALU_EXEC_MUL_EN
    localparam logic [5:0] F_MUL  = 6'b011000;
`endif

    // Signed overflow: both operands share a sign the sum does not keep.
    function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                     input logic signed [WIDTH-1:0] y,
                                     input logic signed [WIDTH-1:0] r);
        return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    // Signed overflow on x - y: operand signs differ and the difference
    // takes the sign of the subtrahend.
    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x,
                                     input logic signed [WIDTH-1:0] y,
                                     input logic signed [WIDTH-1:0] r);
        return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    // Single-cycle operation; returns {ovf, result}.
    function automatic logic [WIDTH:0] alu_calc(input logic [1:0]              op,
                                                input logic [5:0]              fn,
                                                input logic [SHW-1:0]          sh,
                                                input logic signed [WIDTH-1:0] x,
                                                input logic signed [WIDTH-1:0] y);
        logic signed [WIDTH-1:0] r;
        logic                    v;
        r = '0;
        v = 1'b0;
        case (op)
            2'b00: begin
                r = x + y;
                v = add_ovf(x, y, r);
            end
            2'b01: begin
                r = x - y;
                v = sub_ovf(x, y, r);
            end
            2'b11: r = x | y;
            default: begin
                case (fn)
                    F_ADD: begin
                        r = x + y;
                        v = add_ovf(x, y, r);
                    end
                    F_SUB: begin
                        r = x - y;
                        v = sub_ovf(x, y, r);
                    end
                    F_AND:  r = x & y;
                    F_OR:   r = x | y;
                    F_XOR:  r = x ^ y;
                    F_NOR:  r = ~(x | y);
                    F_SLT:  r = {{(WIDTH-1){1'b0}}, (x < y)};
                    F_SLTU: r = {{(WIDTH-1){1'b0}}, ($unsigned(x) < $unsigned(y))};
                    F_SLL:  r = y << sh;
                    F_SRL:  r = $unsigned(y) >> sh;
                    F_SRA:  r = y >>> sh;
                    default: r = '0;
                endcase
            end
        endcase
        return {v, r};
    endfunction

    logic [1:0]       state;
    logic             take_in;
    logic             take_out;
    logic [WIDTH:0]   calc;

`ifdef ALU_EXEC_MUL_EN
    logic             is_mul;
    logic             mul_fin;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] mcand_p0;
    logic [WIDTH-1:0] mplier_p0;
    logic [WIDTH-1:0] acc_p0;

    assign is_mul = (alu_op == 2'b10) && (funct == F_MUL);
`endif

    // in_ready folds in rst_n so nothing is accepted while reset is held.
    assign in_ready  = rst_n && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
    assign out_valid = (state == S_DONE);
    assign take_in   = in_valid && in_ready;
    assign take_out  = out_valid && out_ready;
    assign calc      = alu_calc(alu_op, funct, shamt, a, b);

    // Stage p0: result registers and handshake state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            result  <= '0;
            zero    <= 1'b1;
            ovf     <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
            cnt     <= '0;
            mul_fin <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // A transfer-in in DONE also consumes the old result when
                    // out_ready is high, so there is no bubble.
                    if (take_in) begin
`ifdef ALU_EXEC_MUL_EN
                        if (is_mul) begin
                            state   <= S_MUL;
                            cnt     <= '0;
                            mul_fin <= 1'b0;
                        end else begin
                            state  <= S_DONE;
                            result <= calc[WIDTH-1:0];
                            zero   <= (calc[WIDTH-1:0] == '0);
                            ovf    <= calc[WIDTH];
                        end
`else
                        state  <= S_DONE;
                        result <= calc[WIDTH-1:0];
                        zero   <= (calc[WIDTH-1:0] == '0);
                        ovf    <= calc[WIDTH];
`endif
                    end else if (take_out) begin
                        state <= S_IDLE;
                    end
                end
`ifdef ALU_EXEC_MUL_EN
                S_MUL: begin
                    // Iterations run on the WIDTH edges after the start; the
                    // edge after the last one publishes the product.
                    if (mul_fin) begin
                        state   <= S_DONE;
                        result  <= acc_p0;
                        zero    <= (acc_p0 == '0);
                        ovf     <= 1'b0;
                        mul_fin <= 1'b0;
                        cnt     <= '0;
                    end else if (cnt == CNT_LAST) begin
                        mul_fin <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_EXEC_MUL_EN
    // Stage p0: shift-add multiplier datapath, operands captured at start
    always_ff @(posedge clk) begin
        if (take_in && is_mul) begin
            mcand_p0  <= a;
            mplier_p0 <= b;
            acc_p0    <= '0;
        end else if ((state == S_MUL) && !mul_fin) begin
            if (mplier_p0[0]) begin
                acc_p0 <= acc_p0 + mcand_p0;
            end
            mcand_p0  <= mcand_p0 << 1;
            mplier_p0 <= mplier_p0 >> 1;
        end
    end
`endif

endmodule
